keystream_gen: RTL

KEYSTREAM_GEN -- requirements
Module: keystream_gen

---
 rtl/keystream_gen_if.sv | 23 ++
 rtl/keystream_gen.sv | 86 ++++++++
 2 files changed

// File: rtl/keystream_gen_if.sv
// rtl/keystream_gen_if.sv - seed/keystream handshake bundle for keystream_gen
interface keystream_gen_if;
    logic [15:0] seed_in;
    logic        seed_load;
    logic [7:0]  key_out;
    logic        key_valid;
    logic        key_ready;
    logic        busy;
    logic [7:0]  byte_cnt;
    logic [15:0] lfsr_state;

    // generator side
    modport master (
        input  seed_in, seed_load, key_ready,
        output key_out, key_valid, busy, byte_cnt, lfsr_state
    );

    // seeding / consuming side
    modport slave (
        output seed_in, seed_load, key_ready,
        input  key_out, key_valid, busy, byte_cnt, lfsr_state
    );
endinterface

// File: rtl/keystream_gen.sv
// rtl/keystream_gen.sv - Galois LFSR keystream byte generator with valid/ready output
module keystream_gen (
    input  logic             clk,
    input  logic             rst,
    keystream_gen_if.master  ks
);
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;

    state_t      state, state_next;
    logic [15:0] lfsr;
    logic [7:0]  key_sh;
    logic [2:0]  bit_cnt;
    logic [7:0]  key_out_r;
    logic        key_valid_r;
    logic [7:0]  byte_cnt_r;

    logic [15:0] lfsr_shifted;
    logic [15:0] seed_eff;
    logic        handshake;
    logic        do_shift;
    logic        byte_done;

    // an all-zero seed would lock the LFSR, so it falls back to the default
    assign seed_eff     = (ks.seed_in == 16'h0000) ? LFSR_DEFAULT : ks.seed_in;
    assign lfsr_shifted = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);

    // next-state and per-cycle control; seed_load overrides every other transition
    always_comb begin
        state_next = state;
        handshake  = key_valid_r && ks.key_ready;
        do_shift   = (state == GEN) && !ks.seed_load;
        byte_done  = do_shift && (bit_cnt == 3'd7);
        case (state)
            IDLE:    state_next = IDLE;
            GEN:     if (bit_cnt == 3'd7) state_next = HOLD;
            HOLD:    if (handshake) state_next = GEN;
            default: state_next = IDLE;
        endcase
        if (ks.seed_load) begin
            state_next = GEN;
        end
    end

    // state, LFSR, byte assembly and accepted-byte counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lfsr        <= LFSR_DEFAULT;
            key_sh      <= 8'h00;
            bit_cnt     <= 3'd0;
            key_out_r   <= 8'h00;
            key_valid_r <= 1'b0;
            byte_cnt_r  <= 8'h00;
        end else begin
            state       <= state_next;
            key_valid_r <= (state_next == HOLD);
            if (ks.seed_load) begin
                lfsr       <= seed_eff;
                key_sh     <= 8'h00;
                bit_cnt    <= 3'd0;
                byte_cnt_r <= 8'h00;
            end else begin
                if (do_shift) begin
                    lfsr    <= lfsr_shifted;
                    key_sh  <= {key_sh[6:0], lfsr[0]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    key_out_r <= {key_sh[6:0], lfsr[0]};
                end
                if (handshake) begin
                    byte_cnt_r <= byte_cnt_r + 8'd1;
                end
            end
        end
    end

    assign ks.key_out    = key_out_r;
    assign ks.key_valid  = key_valid_r;
    assign ks.busy       = (state == GEN);
    assign ks.byte_cnt   = byte_cnt_r;
    assign ks.lfsr_state = lfsr;
endmodule
